square_channel_gen: RTL



---
 rtl/square_channel_gen_if.sv | 34 +++
 rtl/square_channel_gen.sv | 124 ++++++++++++
 2 files changed

// File: rtl/square_channel_gen_if.sv
// Control and sample bus of the pulse channel 1 square-wave generator.
// The register block / sweep unit side drives it as master; the generator is the slave.
interface square_channel_gen_if #(
    parameter int FREQ_W = 11,
    parameter int VOL_W  = 4
);
    logic              tick_freq;
    logic              tick_len;
    logic              tick_env;
    logic              trigger;
    logic              length_enable;
    logic [FREQ_W-1:0] freq_in;
    logic              sweep_ok;
    logic [1:0]        duty;
    logic [5:0]        length_load;
    logic [VOL_W-1:0]  env_init_vol;
    logic              env_increase;
    logic [2:0]        env_period;
    logic [VOL_W-1:0]  sample;
    logic              wave_bit;
    logic              active;

    modport master (
        output tick_freq, tick_len, tick_env, trigger, length_enable, freq_in,
               sweep_ok, duty, length_load, env_init_vol, env_increase, env_period,
        input  sample, wave_bit, active
    );

    modport slave (
        input  tick_freq, tick_len, tick_env, trigger, length_enable, freq_in,
               sweep_ok, duty, length_load, env_init_vol, env_increase, env_period,
        output sample, wave_bit, active
    );
endinterface

// File: rtl/square_channel_gen.sv
// Square-wave generator for pulse channel 1: frequency timer, 8-step duty
// sequencer, length counter and volume envelope, producing the 4-bit sample
// that feeds the channel mixer.
module square_channel_gen #(
    parameter int FREQ_W = 11,
    parameter int VOL_W  = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    square_channel_gen_if.slave bus
);
    localparam int TIMER_W = FREQ_W + 1;
    localparam logic [TIMER_W-1:0] PERIOD_MAX = TIMER_W'(1) << FREQ_W;
    localparam logic [VOL_W-1:0]   VOL_MAX    = '1;

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         step_q, step_d;
    logic [6:0]         lenCount_q, lenCount_d;
    logic [VOL_W-1:0]   volume_q, volume_d;
    logic [2:0]         envTimer_q, envTimer_d;
    logic               active_q, active_d;

    logic [TIMER_W-1:0] timerReload;
    logic               dacOn;
    logic [7:0]         dutyPattern;
    logic               patternBit;

    assign timerReload = PERIOD_MAX - {1'b0, bus.freq_in};
    assign dacOn       = (bus.env_init_vol != '0) || bus.env_increase;

    // Duty waveform lookup; bit n is the output level at sequencer step n.
    always_comb begin
        dutyPattern = 8'b1000_0000;
        case (bus.duty)
            2'b00: dutyPattern = 8'b1000_0000;
            2'b01: dutyPattern = 8'b1000_0001;
            2'b10: dutyPattern = 8'b1110_0001;
            2'b11: dutyPattern = 8'b0111_1110;
            default: dutyPattern = 8'b1000_0000;
        endcase
    end

    assign patternBit   = dutyPattern[step_q];
    assign bus.wave_bit = active_q & patternBit;
    assign bus.sample   = (active_q && patternBit) ? volume_q : '0;
    assign bus.active   = active_q;

    // Next-state logic: a trigger reloads everything and masks all ticks that
    // cycle; otherwise each tick advances its own counter and the channel is
    // shut off by sweep overflow, a dead DAC or length expiry.
    always_comb begin
        timer_d    = timer_q;
        step_d     = step_q;
        lenCount_d = lenCount_q;
        volume_d   = volume_q;
        envTimer_d = envTimer_q;
        active_d   = active_q;

        if (bus.trigger) begin
            timer_d    = timerReload;
            step_d     = 3'd0;
            lenCount_d = 7'd64 - {1'b0, bus.length_load};
            volume_d   = bus.env_init_vol;
            envTimer_d = bus.env_period;
            active_d   = dacOn && bus.sweep_ok;
        end else begin
            if (bus.tick_freq && active_q) begin
                if (timer_q <= TIMER_W'(1)) begin
                    timer_d = timerReload;
                    step_d  = step_q + 3'd1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            if (bus.tick_len && bus.length_enable && (lenCount_q != 7'd0)) begin
                lenCount_d = lenCount_q - 7'd1;
                if (lenCount_q == 7'd1) begin
                    active_d = 1'b0;
                end
            end

            if (bus.tick_env && active_q && (bus.env_period != 3'd0)) begin
                if (envTimer_q <= 3'd1) begin
                    envTimer_d = bus.env_period;
                    if (bus.env_increase) begin
                        if (volume_q != VOL_MAX) begin
                            volume_d = volume_q + VOL_W'(1);
                        end
                    end else begin
                        if (volume_q != '0) begin
                            volume_d = volume_q - VOL_W'(1);
                        end
                    end
                end else begin
                    envTimer_d = envTimer_q - 3'd1;
                end
            end

            if (!bus.sweep_ok || !dacOn) begin
                active_d = 1'b0;
            end
        end
    end

    // Channel state registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_q    <= '0;
            step_q     <= 3'd0;
            lenCount_q <= 7'd0;
            volume_q   <= '0;
            envTimer_q <= 3'd0;
            active_q   <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            step_q     <= step_d;
            lenCount_q <= lenCount_d;
            volume_q   <= volume_d;
            envTimer_q <= envTimer_d;
            active_q   <= active_d;
        end
    end
endmodule
